// File: rtl/force_accumulator_writer.sv
// Sums NEIGHBOR_NUM consecutive pair forces per home particle and writes the
// saturated total to the home-indexed force BRAM port, pulsing done after HOME_NUM writes.
module force_accumulator_writer #(
    parameter int DATA_WIDTH     = 32,
    parameter int NEIGHBOR_NUM   = 512,
    parameter int NEIGHBOR_WIDTH = 9,
    parameter int HOME_NUM       = 512,
    parameter int HOME_WIDTH     = 9,
    parameter int ACC_WIDTH      = 41
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] force_in_x,
    input  logic signed [DATA_WIDTH-1:0] force_in_y,
    input  logic signed [DATA_WIDTH-1:0] force_in_z,
    input  logic                         force_in_valid,
    output logic                         force_wr_en,
    output logic [HOME_WIDTH-1:0]        force_wr_addr,
    output logic signed [DATA_WIDTH-1:0] force_wr_data_x,
    output logic signed [DATA_WIDTH-1:0] force_wr_data_y,
    output logic signed [DATA_WIDTH-1:0] force_wr_data_z,
    output logic                         busy,
    output logic                         done,
    output logic                         sat_flag,
    output logic                         drop_flag
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [NEIGHBOR_WIDTH-1:0] NBR_LAST  = NEIGHBOR_WIDTH'(NEIGHBOR_NUM - 1);
    localparam logic [HOME_WIDTH-1:0]     HOME_LAST = HOME_WIDTH'(HOME_NUM - 1);

    // Signed DATA_WIDTH limits expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] MAX_ACC =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_ACC =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic ovf(input logic signed [ACC_WIDTH-1:0] v);
        return (v > MAX_ACC) || (v < MIN_ACC);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        if (v > MAX_ACC)
            return MAX_ACC[DATA_WIDTH-1:0];
        else if (v < MIN_ACC)
            return MIN_ACC[DATA_WIDTH-1:0];
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]                    state_q, state_d;
    logic [NEIGHBOR_WIDTH-1:0]     nbr_cnt_q, nbr_cnt_d;
    logic [HOME_WIDTH-1:0]         home_cnt_q, home_cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
    logic                          wr_en_q, wr_en_d;
    logic [HOME_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic signed [DATA_WIDTH-1:0]  wr_x_q, wr_x_d, wr_y_q, wr_y_d, wr_z_q, wr_z_d;
    logic                          sat_q, sat_d;
    logic                          drop_q, drop_d;

    logic signed [ACC_WIDTH-1:0]   ext_x, ext_y, ext_z;
    logic signed [ACC_WIDTH-1:0]   sum_x, sum_y, sum_z;

    assign ext_x = {{(ACC_WIDTH-DATA_WIDTH){force_in_x[DATA_WIDTH-1]}}, force_in_x};
    assign ext_y = {{(ACC_WIDTH-DATA_WIDTH){force_in_y[DATA_WIDTH-1]}}, force_in_y};
    assign ext_z = {{(ACC_WIDTH-DATA_WIDTH){force_in_z[DATA_WIDTH-1]}}, force_in_z};
    assign sum_x = acc_x_q + ext_x;
    assign sum_y = acc_y_q + ext_y;
    assign sum_z = acc_z_q + ext_z;

    always_comb begin
        state_d    = state_q;
        nbr_cnt_d  = nbr_cnt_q;
        home_cnt_d = home_cnt_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        acc_z_d    = acc_z_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_z_d     = wr_z_q;
        sat_d      = sat_q;
        drop_d     = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACCUM;
                    nbr_cnt_d  = '0;
                    home_cnt_d = '0;
                    acc_x_d    = '0;
                    acc_y_d    = '0;
                    acc_z_d    = '0;
                    sat_d      = 1'b0;
                    drop_d     = 1'b0;
                end else if (force_in_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (force_in_valid) begin
                    if (nbr_cnt_q == NBR_LAST) begin
                        // Last pair of this home: emit the total and restart the sum
                        // so the next cycle's pair can stream in without a bubble.
                        wr_en_d    = 1'b1;
                        wr_addr_d  = home_cnt_q;
                        wr_x_d     = sat(sum_x);
                        wr_y_d     = sat(sum_y);
                        wr_z_d     = sat(sum_z);
                        sat_d      = sat_q | ovf(sum_x) | ovf(sum_y) | ovf(sum_z);
                        acc_x_d    = '0;
                        acc_y_d    = '0;
                        acc_z_d    = '0;
                        nbr_cnt_d  = '0;
                        home_cnt_d = home_cnt_q + HOME_WIDTH'(1);
                        if (home_cnt_q == HOME_LAST)
                            state_d = ST_DONE;
                    end else begin
                        acc_x_d   = sum_x;
                        acc_y_d   = sum_y;
                        acc_z_d   = sum_z;
                        nbr_cnt_d = nbr_cnt_q + NEIGHBOR_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (force_in_valid)
                    drop_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            nbr_cnt_q  <= '0;
            home_cnt_q <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            acc_z_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_z_q     <= '0;
            sat_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nbr_cnt_q  <= nbr_cnt_d;
            home_cnt_q <= home_cnt_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            acc_z_q    <= acc_z_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_z_q     <= wr_z_d;
            sat_q      <= sat_d;
            drop_q     <= drop_d;
        end
    end

    assign force_wr_en     = wr_en_q;
    assign force_wr_addr   = wr_addr_q;
    assign force_wr_data_x = wr_x_q;
    assign force_wr_data_y = wr_y_q;
    assign force_wr_data_z = wr_z_q;
    assign busy            = (state_q == ST_ACCUM);
    assign done            = (state_q == ST_DONE);
    assign sat_flag        = sat_q;
    assign drop_flag       = drop_q;

endmodule

// File: tb/tb_force_accumulator_writer.sv
// Bench for force_accumulator_writer with 4 pairs per home and 2 homes per run;
// expected writes go into a queue when the last pair is driven and are checked as they appear.
module tb_force_accumulator_writer;

    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic signed [DW-1:0] fx, fy, fz;
    logic                 fvalid;
    logic                 wr_en;
    logic [0:0]           wr_addr;
    logic signed [DW-1:0] wx, wy, wz;
    logic                 busy, done, sat_flag, drop_flag;

    force_accumulator_writer #(
        .DATA_WIDTH(32), .NEIGHBOR_NUM(4), .NEIGHBOR_WIDTH(2),
        .HOME_NUM(2), .HOME_WIDTH(1), .ACC_WIDTH(34)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .force_in_x(fx), .force_in_y(fy), .force_in_z(fz),
        .force_in_valid(fvalid),
        .force_wr_en(wr_en), .force_wr_addr(wr_addr),
        .force_wr_data_x(wx), .force_wr_data_y(wy), .force_wr_data_z(wz),
        .busy(busy), .done(done), .sat_flag(sat_flag), .drop_flag(drop_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [0:0]           addr;
        logic signed [DW-1:0] x, y, z;
        bit                   last;
        int                   cyc;
    } wr_t;
    wr_t sbq[$];

    typedef struct {
        logic signed [DW-1:0] x0, dx, y0, dy, z0, dz;
        bit                   gap;
        logic signed [DW-1:0] ex0, ex1, ey0, ey1, ez0, ez1;
        bit                   esat;
    } row_t;
    row_t rows[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check("done_with_wr", wr_en, 1);
            check("busy_at_done", busy, 0);
        end
        if (wr_en) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_wr: got write addr %0d x %0h, required no write (t=%0t)",
                         wr_addr, wx, $time);
            end else begin
                wr_t e;
                e = sbq.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_x", wx, e.x);
                check("wr_y", wy, e.y);
                check("wr_z", wz, e.z);
                check("wr_done", done, e.last);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step(input bit v, input logic signed [DW-1:0] x, y, z);
        fvalid = v;
        fx = x;
        fy = y;
        fz = z;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [0:0] a, input logic signed [DW-1:0] x, y, z, input bit last);
        wr_t e;
        e.addr = a;
        e.x = x;
        e.y = y;
        e.z = z;
        e.last = last;
        e.cyc = cyc + 1;
        sbq.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(0, 0, 0, 0);
        start = 1'b0;
    endtask

    task automatic finish_run(input int d0, input bit esat);
        repeat (3) step(0, 0, 0, 0);
        check("done_count", done_cnt, d0 + 1);
        check("sb_empty", sbq.size(), 0);
        check("sat_flag", sat_flag, esat);
        check("drop_flag", drop_flag, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic run_row(input row_t r);
        int d0;
        d0 = done_cnt;
        pulse_start();
        check("busy_run", busy, 1);
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = h * 4 + k;
                if (k == 3)
                    push(h[0:0], h == 0 ? r.ex0 : r.ex1, h == 0 ? r.ey0 : r.ey1,
                         h == 0 ? r.ez0 : r.ez1, h == 1);
                step(1, r.x0 + r.dx * i, r.y0 + r.dy * i, r.z0 + r.dz * i);
                if (r.gap) step(0, 999, 999, 999);
            end
        end
        finish_run(d0, r.esat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // x0, dx, y0, dy, z0, dz, gap, ex0, ex1, ey0, ey1, ez0, ez1, esat
        rows[0] = '{1, 0, -2, 0, 3, 0, 1'b0, 4, 4, -8, -8, 12, 12, 1'b0};
        rows[1] = '{1, 1, -1, -1, 0, 0, 1'b1, 10, 26, -10, -26, 0, 0, 1'b0};
        rows[2] = '{32'h7FFF_FFF0, 0, 32'h8000_0000, 0, -5, 0, 1'b0,
                    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, -20, -20, 1'b1};
        rows[3] = '{100, -60, 7, 0, -1, 1, 1'b0, 40, -920, 28, 28, 2, 18, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        fvalid = 1'b0;
        fx = '0;
        fy = '0;
        fz = '0;
        #3;
        check("rst_wr_en", wr_en, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_x", wx, 0);
        check("rst_y", wy, 0);
        check("rst_z", wz, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_drop", drop_flag, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        for (int r = 0; r < 4; r++) run_row(rows[r]);

        // Inputs before start are dropped; start pulses mid-run are ignored.
        step(1, 1000, 1000, 1000);
        step(1, 1000, 1000, 1000);
        step(1, 1000, 1000, 1000);
        check("drop_set", drop_flag, 1);
        check("drop_no_busy", busy, 0);
        d0 = done_cnt;
        pulse_start();
        check("drop_cleared", drop_flag, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 7) push(i == 3 ? 1'b0 : 1'b1, 4, 4, 4, i == 7);
            start = (i == 3 || i == 5);
            step(1, 1, 1, 1);
        end
        start = 1'b0;
        finish_run(d0, 0);

        // Asynchronous reset after 5 of 8 inputs abandons the run.
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) push(0, 4, 4, 4, 0);
            step(1, 1, 1, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_x", wx, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_drop", drop_flag, 0);
        @(posedge clk);
        #1;
        step(0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (5) step(0, 0, 0, 0);
        check("arst_no_done", done_cnt, d0);
        check("arst_sb_empty", sbq.size(), 0);
        check("arst_idle", busy, 0);
        run_row(rows[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
